// File: rtl/ext_pkg.sv
// Shared mode codes for the immediate extender.
// The EXT_BRANCH_TGT_EN build option lives in ext_core/ext_pipe; nothing here depends on it.
package ext_pkg;
  localparam int EOP_W = 3;

  localparam logic [EOP_W-1:0] EOP_ZERO  = 3'd0;
  localparam logic [EOP_W-1:0] EOP_SIGN  = 3'd1;
  localparam logic [EOP_W-1:0] EOP_LUI   = 3'd2;
  localparam logic [EOP_W-1:0] EOP_BOFS  = 3'd3;
  localparam logic [EOP_W-1:0] EOP_SHAMT = 3'd4;
endpackage

// File: rtl/ext_core.sv
// Combinational mode decode and extension; returns {err, ext}.
// With EXT_BRANCH_TGT_EN defined, branch-offset mode adds pc + 4 to form a target.
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [EOP_W-1:0]  eop_i,
`ifdef EXT_BRANCH_TGT_EN
  input  logic [DATA_W-1:0] pc_i,
`endif
  output logic [DATA_W:0]   res_o
);

  logic signed [DATA_W-1:0] sext;
  logic signed [DATA_W-1:0] bofs;

  always_comb begin
    sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    bofs = {sext[DATA_W-3:0], 2'b00};
    res_o = '0;
    unique case (eop_i)
      EOP_ZERO:  res_o = {1'b0, {(DATA_W-IMM_W){1'b0}}, imm_i};
      EOP_SIGN:  res_o = {1'b0, sext};
      EOP_LUI:   res_o = {1'b0, imm_i, {(DATA_W-IMM_W){1'b0}}};
`ifdef EXT_BRANCH_TGT_EN
      EOP_BOFS:  res_o = {1'b0, pc_i + DATA_W'(4) + bofs};
`else
      EOP_BOFS:  res_o = {1'b0, bofs};
`endif
      EOP_SHAMT: res_o = {1'b0, {(DATA_W-5){1'b0}}, imm_i[10:6]};
      // Undefined codes: zero operand flagged as an error.
      default:   res_o = {1'b1, {DATA_W{1'b0}}};
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate extender: one output register plus a one-entry skid buffer.
// Define EXT_BRANCH_TGT_EN to add in_pc and turn branch-offset mode into a target adder.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [EOP_W-1:0]  in_eop,
`ifdef EXT_BRANCH_TGT_EN
  input  logic [DATA_W-1:0] in_pc,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ext,
  output logic              out_err
);

  logic [DATA_W:0]   core_res;

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_ext_q, out_ext_d;
  logic              out_err_q, out_err_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_ext_q, skid_ext_d;
  logic              skid_err_q, skid_err_d;

  ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .imm_i (in_imm),
    .eop_i (in_eop),
`ifdef EXT_BRANCH_TGT_EN
    .pc_i  (in_pc),
`endif
    .res_o (core_res)
  );

  always_comb begin
    out_vld_d  = out_vld_q;
    out_ext_d  = out_ext_q;
    out_err_d  = out_err_q;
    skid_vld_d = skid_vld_q;
    skid_ext_d = skid_ext_q;
    skid_err_d = skid_err_q;
    if (!out_vld_q || out_ready) begin
      // Output slot frees up: older skid entry has priority to keep FIFO order.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_ext_d  = skid_ext_q;
        out_err_d  = skid_err_q;
        skid_vld_d = 1'b0;
      end else if (in_valid) begin
        out_vld_d = 1'b1;
        out_ext_d = core_res[DATA_W-1:0];
        out_err_d = core_res[DATA_W];
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_valid && !skid_vld_q) begin
      skid_vld_d = 1'b1;
      skid_ext_d = core_res[DATA_W-1:0];
      skid_err_d = core_res[DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_ext_q  <= '0;
      out_err_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_ext_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_ext_q  <= out_ext_d;
      out_err_q  <= out_err_d;
      skid_vld_q <= skid_vld_d;
      skid_ext_q <= skid_ext_d;
      skid_err_q <= skid_err_d;
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = out_vld_q;
  assign out_ext   = out_ext_q;
  assign out_err   = out_err_q;

endmodule
